// File: rtl/riscv_pkg.sv
// Shared RV32 datapath widths, ALU opcode map and the ID/EX payload type.
package riscv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned ALU_W = 4;
  localparam int unsigned CNT_W = 16;

  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_PASB = 4'b1001;
  localparam logic [ALU_W-1:0] ALU_ASR  = 4'b1010;

  typedef struct packed {
    logic             illegal;
    logic             reg_write;
    logic [REG_W-1:0] rd_addr;
    logic [ALU_W-1:0] alu_ctrl;
    logic [XLEN-1:0]  b;
    logic [XLEN-1:0]  a;
  } ex_payload_t;

  // Codes above the highest defined opcode have no ALU meaning.
  function automatic logic alu_is_illegal(input logic [ALU_W-1:0] ctrl);
    return ctrl > ALU_ASR;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass: EX/MEM result beats MEM/WB result beats register file; x0 never bypassed.
module fwd_mux
  import riscv_pkg::*;
(
  input  logic [REG_W-1:0] src_addr_i,
  input  logic [XLEN-1:0]  rf_data_i,
  input  logic             exm_wr_i,
  input  logic [REG_W-1:0] exm_rd_i,
  input  logic [XLEN-1:0]  exm_data_i,
  input  logic             mwb_wr_i,
  input  logic [REG_W-1:0] mwb_rd_i,
  input  logic [XLEN-1:0]  mwb_data_i,
  output logic [XLEN-1:0]  fwd_data_c_o
);

  logic src_nonzero;
  assign src_nonzero = (src_addr_i != REG_W'(0));

  always_comb begin
    fwd_data_c_o = rf_data_i;
    if (src_nonzero && exm_wr_i && (exm_rd_i == src_addr_i)) begin
      fwd_data_c_o = exm_data_i;
    end else if (src_nonzero && mwb_wr_i && (mwb_rd_i == src_addr_i)) begin
      fwd_data_c_o = mwb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-entry valid/ready slot with operand forwarding,
// illegal-opcode screening and an issue counter.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [REG_W-1:0] in_rs1_addr,
  input  logic [REG_W-1:0] in_rs2_addr,
  input  logic [REG_W-1:0] in_rd_addr,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_use_imm,
  input  logic [ALU_W-1:0] in_alu_ctrl,
  input  logic             in_reg_write,
  input  logic             exm_wr,
  input  logic [REG_W-1:0] exm_rd,
  input  logic [XLEN-1:0]  exm_data,
  input  logic             mwb_wr,
  input  logic [REG_W-1:0] mwb_rd,
  input  logic [XLEN-1:0]  mwb_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_a,
  output logic [XLEN-1:0]  out_b,
  output logic [ALU_W-1:0] out_alu_ctrl,
  output logic [REG_W-1:0] out_rd_addr,
  output logic             out_reg_write,
  output logic             out_illegal,
  output logic [CNT_W-1:0] issue_count
);

  logic             valid_q, valid_d;
  ex_payload_t      payload_q, payload_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  rs1_fwd, rs2_fwd;
  logic             capture;
  logic             illegal;

  fwd_mux u_fwd_rs1 (
    .src_addr_i   (in_rs1_addr),
    .rf_data_i    (in_rs1_data),
    .exm_wr_i     (exm_wr),
    .exm_rd_i     (exm_rd),
    .exm_data_i   (exm_data),
    .mwb_wr_i     (mwb_wr),
    .mwb_rd_i     (mwb_rd),
    .mwb_data_i   (mwb_data),
    .fwd_data_c_o (rs1_fwd)
  );

  fwd_mux u_fwd_rs2 (
    .src_addr_i   (in_rs2_addr),
    .rf_data_i    (in_rs2_data),
    .exm_wr_i     (exm_wr),
    .exm_rd_i     (exm_rd),
    .exm_data_i   (exm_data),
    .mwb_wr_i     (mwb_wr),
    .mwb_rd_i     (mwb_rd),
    .mwb_data_i   (mwb_data),
    .fwd_data_c_o (rs2_fwd)
  );

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign illegal  = alu_is_illegal(in_alu_ctrl);

  // Flush dominates capture and drain; data may stay stale once invalidated.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    count_d   = count_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d             = 1'b1;
      payload_d.a         = rs1_fwd;
      payload_d.b         = in_use_imm ? in_imm : rs2_fwd;
      payload_d.alu_ctrl  = in_alu_ctrl;
      payload_d.rd_addr   = in_rd_addr;
      payload_d.reg_write = in_reg_write && !illegal;
      payload_d.illegal   = illegal;
      count_d             = count_q + CNT_W'(1);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      count_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      count_q   <= count_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_a         = payload_q.a;
  assign out_b         = payload_q.b;
  assign out_alu_ctrl  = payload_q.alu_ctrl;
  assign out_rd_addr   = payload_q.rd_addr;
  assign out_reg_write = payload_q.reg_write;
  assign out_illegal   = payload_q.illegal;
  assign issue_count   = count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, forwarding, stall, flush, illegal codes, reset, counter wrap.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic        in_use_imm, in_reg_write;
  logic [3:0]  in_alu_ctrl;
  logic        exm_wr, mwb_wr;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_data, mwb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic [3:0]  out_alu_ctrl;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write, out_illegal;
  logic [15:0] issue_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rs1_data   (in_rs1_data),
    .in_rs2_data   (in_rs2_data),
    .in_rs1_addr   (in_rs1_addr),
    .in_rs2_addr   (in_rs2_addr),
    .in_rd_addr    (in_rd_addr),
    .in_imm        (in_imm),
    .in_use_imm    (in_use_imm),
    .in_alu_ctrl   (in_alu_ctrl),
    .in_reg_write  (in_reg_write),
    .exm_wr        (exm_wr),
    .exm_rd        (exm_rd),
    .exm_data      (exm_data),
    .mwb_wr        (mwb_wr),
    .mwb_rd        (mwb_rd),
    .mwb_data      (mwb_data),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_a         (out_a),
    .out_b         (out_b),
    .out_alu_ctrl  (out_alu_ctrl),
    .out_rd_addr   (out_rd_addr),
    .out_reg_write (out_reg_write),
    .out_illegal   (out_illegal),
    .issue_count   (issue_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_a"}, out_a, 32'h0);
    chk({tag, "_b"}, out_b, 32'h0);
    chk({tag, "_ctrl"}, 32'(out_alu_ctrl), 32'h0);
    chk({tag, "_rd"}, 32'(out_rd_addr), 32'h0);
    chk({tag, "_rw"}, 32'(out_reg_write), 32'h0);
    chk({tag, "_ill"}, 32'(out_illegal), 32'h0);
    chk({tag, "_cnt"}, 32'(issue_count), 32'h0);
    chk({tag, "_rdy"}, 32'(in_ready), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
    in_use_imm = 0; in_reg_write = 0; in_alu_ctrl = 0;
    exm_wr = 0; exm_rd = 0; exm_data = 0;
    mwb_wr = 0; mwb_rd = 0; mwb_data = 0;
    flush = 0; out_ready = 0;

    #12;
    check_all_zero("reset");
    #4 rst_n = 1'b1;
    step();

    // basic capture, one-cycle latency
    in_valid = 1; in_rs1_addr = 1; in_rs2_addr = 2; in_rs1_data = 5; in_rs2_data = 7;
    in_rd_addr = 4; in_reg_write = 1; in_alu_ctrl = 4'b0000; out_ready = 1;
    step();
    chk("cap_valid", 32'(out_valid), 32'h1);
    chk("cap_a", out_a, 32'd5);
    chk("cap_b", out_b, 32'd7);
    chk("cap_rd", 32'(out_rd_addr), 32'd4);
    chk("cap_rw", 32'(out_reg_write), 32'h1);
    chk("cap_cnt", 32'(issue_count), 32'd1);
    in_valid = 0;
    step();
    chk("drain_valid", 32'(out_valid), 32'h0);
    chk("drain_cnt", 32'(issue_count), 32'd1);

    // forwarding priority
    in_valid = 1; in_rs1_addr = 3; in_rs2_addr = 3; in_rs1_data = 32'hAA; in_rs2_data = 32'hBB;
    exm_wr = 1; exm_rd = 3; exm_data = 32'h11;
    mwb_wr = 1; mwb_rd = 3; mwb_data = 32'h22;
    step();
    chk("fwd_exm_a", out_a, 32'h11);
    chk("fwd_exm_b", out_b, 32'h11);
    exm_wr = 0;
    step();
    chk("fwd_mwb_a", out_a, 32'h22);
    chk("fwd_mwb_b", out_b, 32'h22);
    exm_wr = 1; in_rs1_addr = 0; exm_rd = 0; mwb_rd = 0;
    step();
    chk("fwd_x0_a", out_a, 32'hAA);
    chk("fwd_x0_cnt", 32'(issue_count), 32'd4);
    exm_wr = 0; mwb_wr = 0;

    // stall: held word stays put, no acceptance
    in_rs1_addr = 0; in_rs2_addr = 0; in_rs1_data = 32'h100; in_rs2_data = 32'h200; in_rd_addr = 7;
    step();
    chk("st_first_a", out_a, 32'h100);
    out_ready = 0; in_rs1_data = 32'h300; in_rd_addr = 9;
    #1 chk("st_rdy0", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_valid", 32'(out_valid), 32'h1);
      chk("st_a", out_a, 32'h100);
      chk("st_rd", 32'(out_rd_addr), 32'd7);
      chk("st_cnt", 32'(issue_count), 32'd5);
      chk("st_rdy", 32'(in_ready), 32'h0);
    end
    out_ready = 1;
    #1 chk("st_rdy1", 32'(in_ready), 32'h1);
    step();
    chk("st_new_a", out_a, 32'h300);
    chk("st_new_rd", 32'(out_rd_addr), 32'd9);
    chk("st_new_cnt", 32'(issue_count), 32'd6);

    // flush with held word and incoming word
    out_ready = 0; flush = 1; in_rs1_data = 32'h400;
    step();
    chk("fl_valid", 32'(out_valid), 32'h0);
    chk("fl_cnt", 32'(issue_count), 32'd6);
    flush = 0; in_valid = 0;
    step();
    chk("fl_valid2", 32'(out_valid), 32'h0);
    chk("fl_rdy", 32'(in_ready), 32'h1);

    // illegal opcodes and immediate operand
    in_valid = 1; out_ready = 1; in_alu_ctrl = 4'b1100; in_reg_write = 1;
    in_use_imm = 1; in_imm = 32'hFFFF_FFF0;
    step();
    chk("ill_flag", 32'(out_illegal), 32'h1);
    chk("ill_rw", 32'(out_reg_write), 32'h0);
    chk("ill_b", out_b, 32'hFFFF_FFF0);
    chk("ill_ctrl", 32'(out_alu_ctrl), 32'hC);
    in_alu_ctrl = 4'b1010;
    step();
    chk("asr_flag", 32'(out_illegal), 32'h0);
    chk("asr_rw", 32'(out_reg_write), 32'h1);
    in_alu_ctrl = 4'b1011;
    step();
    chk("b_flag", 32'(out_illegal), 32'h1);
    chk("b_rw", 32'(out_reg_write), 32'h0);
    chk("b_cnt", 32'(issue_count), 32'd9);

    // async reset while stalled
    in_valid = 0; out_ready = 0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_rst");
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(out_valid), 32'h0);

    // counter wrap
    in_valid = 1; out_ready = 1; in_alu_ctrl = 0; in_use_imm = 0;
    for (int i = 0; i < 65535; i++) step();
    chk("wrap_max", 32'(issue_count), 32'hFFFF);
    step();
    chk("wrap_zero", 32'(issue_count), 32'h0);
    chk("wrap_valid", 32'(out_valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port in_valid  input  1  upstream decode word valid.
REQ-004 SHALL have port in_ready  output  1  stage can accept a word this cycle.
REQ-005 SHALL have ports in_rs1_data, in_rs2_data  input  32  register-file read data.
REQ-006 SHALL have ports in_rs1_addr, in_rs2_addr, in_rd_addr  input  5  source/destination register indices.
REQ-007 SHALL have ports in_imm  input  32 and in_use_imm  input  1  immediate, and select immediate as operand B.
REQ-008 SHALL have ports in_alu_ctrl  input  4 and in_reg_write  input  1  ALU opcode and writeback enable.
REQ-009 SHALL have ports exm_wr  input  1, exm_rd  input  5, exm_data  input  32  EX/MEM forwarding source.
REQ-010 SHALL have ports mwb_wr  input  1, mwb_rd  input  5, mwb_data  input  32  MEM/WB forwarding source.
REQ-011 SHALL have port flush  input  1  discard held and incoming word.
REQ-012 SHALL have ports out_valid  output  1 and out_ready  input  1  downstream handshake toward the ALU.
REQ-013 SHALL have ports out_a, out_b  output  32, out_alu_ctrl  output  4, out_rd_addr  output  5, out_reg_write  output  1, out_illegal  output  1.
REQ-014 SHALL have port issue_count  output  16  number of words accepted since reset.

Function
REQ-015 SHALL hold one registered entry; latency input-to-output exactly 1 cycle.
REQ-016 SHALL drive in_ready = !out_valid || out_ready (combinational, no flush term).
REQ-017 SHALL capture inputs on an edge where in_valid && in_ready && !flush, setting out_valid=1.
REQ-018 SHALL clear out_valid when out_ready && out_valid and no capture occurs in the same edge.
REQ-019 SHALL hold all outputs stable while out_valid && !out_ready (stall).
REQ-020 SHALL compute forwarded rs1: exm_data if exm_wr && exm_rd==rs1 && rs1!=0; else mwb_data if mwb_wr && mwb_rd==rs1 && rs1!=0; else in_rs1_data.
REQ-021 SHALL compute forwarded rs2 identically; EX/MEM has priority over MEM/WB when both match.
REQ-022 SHALL register out_a = forwarded rs1; out_b = in_imm if in_use_imm else forwarded rs2.
REQ-023 SHALL treat register 0 as never forwarded; source addr 0 yields in_rs*_data unchanged.
REQ-024 SHALL set out_illegal=1 and force out_reg_write=0 when captured in_alu_ctrl is 4'b1011..4'b1111; out_alu_ctrl passes the code unchanged.
REQ-025 SHALL on flush clear out_valid at the next edge, ignoring simultaneous capture and out_ready; data registers may keep stale values.
REQ-026 SHALL increment issue_count by 1 per capture, wrapping 16'hFFFF -> 16'h0000; flush does not decrement it.

Reset
REQ-027 SHALL on rst_n low immediately force out_valid=0, out_a=0, out_b=0, out_alu_ctrl=0, out_rd_addr=0, out_reg_write=0, out_illegal=0, issue_count=0.
REQ-028 SHALL drive in_ready=1 during and after reset until first capture; reset asserted mid-stall discards the held word.

Structure
REQ-029 SHALL take XLEN=32, register-index width 5, and ALU opcode constants (ADD 0000 .. ASR 1010, highest legal code) from shared package riscv_pkg.
REQ-030 SHALL implement forwarding in one sub-module fwd_mux, instantiated once per source operand.

Verification
REQ-031 Capture: rs1_data=5, rs2_data=7, ctrl=0000, out_ready=1 -> next cycle out_valid=1, out_a=5, out_b=7, issue_count=1.
REQ-032 Forwarding priority: rs1=3, exm_rd=3 data=0x11, mwb_rd=3 data=0x22, both wr=1 -> out_a=0x11; exm_wr=0 -> out_a=0x22; rs1=0 with matches -> out_a=in_rs1_data.
REQ-033 Stall: out_valid=1, out_ready=0 for 3 cycles, new in_valid -> in_ready=0, outputs unchanged, issue_count unchanged; out_ready=1 -> new word next edge.
REQ-034 Flush: flush=1 with in_valid=1 and held word -> out_valid=0 next cycle, issue_count unchanged.
REQ-035 Illegal/immediate: ctrl=1100, reg_write=1, use_imm=1, imm=0xFFFFFFF0 -> out_illegal=1, out_reg_write=0, out_b=0xFFFFFFF0.
REQ-036 Reset/wrap: 65536 captures -> issue_count=0; rst_n low mid-stall -> all outputs 0 asynchronously, in_ready=1.
